sha256_compress_pipe_ctrl: RTL and testbench
============================================

// Module: sha256_compress_pipe_ctrl
// PURPOSE
// Parametrised successor to the single-adder SHA-256 compression core. Runs one full round per
// clock using a combinational T1/T2 datapath. Supports runtime SHA-224/SHA-256 mode and multi-block
// chaining, where H carries over between blocks. W_t arrives from the message scheduler over a
// valid/ready handshake.
// PARAMETERS
// ROUNDS     64  rounds per block; legal values 1..64. Values below 64 are for reduced-round debug only.
// SHA224_EN  1   1: mode_224 is honoured; 0: mode_224 is ignored and the block is SHA-256 only
// PORTS
// clk          in   1    single clock; all logic on its rising edge
// rst_n        in   1    reset, synchronous, active-low
// start        in   1    begin a block; sampled only in IDLE
// first_block  in   1    sampled with start; 1 loads the IV, 0 chains from the current H
// mode_224     in   1    sampled with start when first_block=1; selects the SHA-224 IV and truncation
// abort        in   1    synchronous abandon of the current block
// w_data       in   32   W_t from the scheduler
// w_valid      in   1    w_data is valid
// w_ready      out  1    core consumes W_t this cycle when w_valid && w_ready
// busy         out  1    high in every state except IDLE
// done         out  1    one-cycle pulse when H has been updated
// digest       out  256  {H0..H7}; H7 field forced to 0 in SHA-224 mode
// digest_valid out  1    digest holds a completed hash; cleared by start or abort
// BEHAVIOUR
// - Reset (rst_n=0 at a clock edge): state=IDLE; a..h, H0..H7, t, and the mode latch go to 0.
//   All outputs are 0. Reset applied mid-block discards the block with no partial H update.
// - FSM states: IDLE -> LOAD -> ROUND -> FINAL -> DONE -> IDLE.
// - IDLE: w_ready=0.
//   - start && !abort with first_block=1: H <= IV (SHA-224 IV if mode_224 && SHA224_EN, else SHA-256 IV),
//     latch the mode, clear digest_valid, go to LOAD.
//   - start with first_block=0: keep H and the latched mode, clear digest_valid, go to LOAD.
// - LOAD: a..h <= H0..H7; t <= 0; go to ROUND.
// - ROUND: w_ready=1.
//   - On w_valid: T1 = h+S1(e)+Ch(e,f,g)+K[t]+w_data; T2 = S0(a)+Maj(a,b,c).
//     Then h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2; t<=t+1.
//     All sums are modulo 2^32. K[t] comes from a 64-entry constant table.
//   - No w_valid: stall; a..h and t hold.
//   - The transfer with t==ROUNDS-1 moves the FSM to FINAL.
// - FINAL: Hi <= Hi + (a..h)i for all 8 words in the same cycle, mod 2^32; go to DONE.
// - DONE: done=1 for exactly one cycle; digest_valid<=1; go to IDLE.
// - Latency: with w_valid held high, done is high in the cycle ROUNDS+3 edges after the edge that
//   sampled start (67 for ROUNDS=64). Each stall cycle adds exactly one cycle.
// - start outside IDLE is ignored.
// - abort:
//   - In any state: go to IDLE on the next edge; digest_valid<=0; H is unchanged.
//   - Abort during FINAL wins; H is not updated and done does not pulse.
//   - abort with start in IDLE: abort wins; no block starts.
// - w_valid outside ROUND is ignored; no data is consumed.
// - digest is stable from DONE until the next FINAL. It is registered from H, with the truncation mask
//   applied when the latched mode is 224.
// - Chaining across modes: the mode is re-latched only when first_block=1.
// TESTING
// - SHA-256 "abc" single padded block, first_block=1, mode_224=0, w_valid always high:
//   digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad;
//   done exactly 67 cycles after start.
// - SHA-224 "abc", mode_224=1:
//   digest = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
// - Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmjklmnklmnomnopnopq" (first_block=1, then 0):
//   digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
// - "abc" with pseudo-random w_valid gaps (N stall cycles in total): same digest as the first test;
//   done at 67+N cycles; no W_t lost or duplicated.
// - abort at t=30, then a fresh first_block "abc" start: digest_valid=0 after the abort, no done pulse,
//   then the correct "abc" digest.
// - rst_n low for 1 cycle during ROUND t=10: on the next cycle all outputs=0 and busy=0; a following
//   "abc" block produces the correct digest.

Source files
------------

// File: rtl/sha256_compress_pipe_ctrl_if.sv
// W_t delivery channel from the message scheduler to the compression core.
// The scheduler is the master; the core is the slave and owns w_ready.
interface sha256_compress_pipe_ctrl_if;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_ready;

    modport master (output w_data, output w_valid, input w_ready);
    modport slave  (input w_data, input w_valid, output w_ready);
endinterface

// File: rtl/sha256_compress_pipe_ctrl.sv
// SHA-256/224 compression core: one round per clock, multi-block chaining through H,
// W_t accepted over a valid/ready channel. All status outputs are registered.
module sha256_compress_pipe_ctrl #(
    parameter int unsigned ROUNDS    = 64,
    parameter bit          SHA224_EN = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic                              first_block_i,
    input  logic                              mode_224_i,
    input  logic                              abort_i,
    sha256_compress_pipe_ctrl_if.slave        w_if,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [255:0]                      digest_o,
    output logic                              digest_valid_o
);

    typedef enum logic [2:0] {StIdle, StLoad, StRound, StFinal, StDone} state_e;

    localparam logic [5:0] LastT = 6'(ROUNDS - 1);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] Iv256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] Iv224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_e        state_q, state_d;
    logic [31:0]   work_q [8];  // a..h at indices 0..7
    logic [31:0]   work_d [8];
    logic [31:0]   h_q [8];
    logic [31:0]   h_d [8];
    logic [5:0]    t_q, t_d;
    logic          mode_q, mode_d;
    logic          dvalid_q, dvalid_d;
    logic          done_q, done_d;
    logic [255:0]  digest_q, digest_d;
    logic [31:0]   t1, t2;
    logic          sel_224;

    always_comb begin
        t1 = work_q[7] + (ror(work_q[4], 6) ^ ror(work_q[4], 11) ^ ror(work_q[4], 25))
           + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6])) + K[t_q] + w_if.w_data;
        t2 = (ror(work_q[0], 2) ^ ror(work_q[0], 13) ^ ror(work_q[0], 22))
           + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));
    end

    assign sel_224 = mode_224_i & SHA224_EN;

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        h_d      = h_q;
        t_d      = t_q;
        mode_d   = mode_q;
        dvalid_d = dvalid_q;
        done_d   = 1'b0;
        digest_d = digest_q;
        if (abort_i) begin
            state_d  = StIdle;
            dvalid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        dvalid_d = 1'b0;
                        state_d  = StLoad;
                        if (first_block_i) begin
                            mode_d = sel_224;
                            h_d    = sel_224 ? Iv224 : Iv256;
                        end
                    end
                end
                StLoad: begin
                    work_d  = h_q;
                    t_d     = '0;
                    state_d = StRound;
                end
                StRound: begin
                    if (w_if.w_valid) begin
                        for (int i = 7; i > 0; i--) work_d[i] = work_q[i-1];
                        work_d[4] = work_q[3] + t1;
                        work_d[0] = t1 + t2;
                        t_d       = t_q + 6'd1;
                        if (t_q == LastT) state_d = StFinal;
                    end
                end
                StFinal: begin
                    for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + work_q[i];
                    state_d = StDone;
                end
                StDone: begin
                    done_d   = 1'b1;
                    dvalid_d = 1'b1;
                    for (int i = 0; i < 8; i++) digest_d[255-32*i -: 32] = h_q[i];
                    if (mode_q) digest_d[31:0] = '0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            t_q      <= '0;
            mode_q   <= 1'b0;
            dvalid_q <= 1'b0;
            done_q   <= 1'b0;
            digest_q <= '0;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= '0;
                h_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            h_q      <= h_d;
            t_q      <= t_d;
            mode_q   <= mode_d;
            dvalid_q <= dvalid_d;
            done_q   <= done_d;
            digest_q <= digest_d;
        end
    end

    assign w_if.w_ready   = (state_q == StRound);
    assign busy_o         = (state_q != StIdle);
    assign done_o         = done_q;
    assign digest_o       = digest_q;
    assign digest_valid_o = dvalid_q;

endmodule

// File: tb/tb_sha256_compress_pipe_ctrl.sv
// Directed bench for sha256_compress_pipe_ctrl: known-answer digests, latency, stalls,
// abort and mid-block reset. The bench plays the message scheduler.
module tb_sha256_compress_pipe_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         first_block = 1'b0;
    logic         mode_224 = 1'b0;
    logic         abort = 1'b0;
    logic         busy, done, dvalid;
    logic [255:0] digest;

    sha256_compress_pipe_ctrl_if w_if ();

    always #5 clk = ~clk;

    sha256_compress_pipe_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .first_block_i  (first_block),
        .mode_224_i     (mode_224),
        .abort_i        (abort),
        .w_if           (w_if),
        .busy_o         (busy),
        .done_o         (done),
        .digest_o       (digest),
        .digest_valid_o (dvalid)
    );

    localparam logic [255:0] DigAbc256 =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DigAbc224 =
        256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam logic [255:0] DigTwo =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    int          total = 0;
    int          bad = 0;
    int          idx, cycles, stalls, pulses;
    logic [31:0] sched [64];
    logic [31:0] abc_blk [16];
    logic [31:0] two1_blk [16];
    logic [31:0] two2_blk [16];

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic expand(input logic [31:0] b [16]);
        for (int t = 0; t < 16; t++) sched[t] = b[t];
        for (int t = 16; t < 64; t++)
            sched[t] = (ror(sched[t-2], 17) ^ ror(sched[t-2], 19) ^ (sched[t-2] >> 10))
                     + sched[t-7]
                     + (ror(sched[t-15], 7) ^ ror(sched[t-15], 18) ^ (sched[t-15] >> 3))
                     + sched[t-16];
    endtask

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic check_i(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Leaves time at #1 after the edge that sampled start.
    task automatic start_block(input logic first, input logic mode);
        @(negedge clk);
        start = 1'b1;
        first_block = first;
        mode_224 = mode;
        w_if.w_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        first_block = 1'b0;
        mode_224 = 1'b0;
    endtask

    // Plays the scheduler until done, `limit` transfers, or a cycle budget runs out.
    task automatic feed(input int gap, input int limit);
        logic fire;
        idx = 0;
        cycles = 0;
        stalls = 0;
        do begin
            w_if.w_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
            w_if.w_data = sched[(idx > 63) ? 63 : idx];
            fire = w_if.w_valid && w_if.w_ready;
            if (w_if.w_ready && !w_if.w_valid) stalls++;
            @(posedge clk);
            #1;
            cycles++;
            if (fire) idx++;
        end while (!done && idx < limit && cycles < 1000);
        w_if.w_valid = 1'b0;
    endtask

    initial begin
        w_if.w_valid = 1'b0;
        w_if.w_data = '0;
        for (int i = 0; i < 16; i++) begin
            abc_blk[i] = '0;
            two2_blk[i] = '0;
        end
        abc_blk[0] = 32'h61626380;
        abc_blk[15] = 32'h00000018;
        two1_blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two2_blk[15] = 32'h000001c0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_done", {255'd0, done}, 256'd0);
        check("rst_dvalid", {255'd0, dvalid}, 256'd0);
        check("rst_digest", digest, 256'd0);
        check("rst_wready", {255'd0, w_if.w_ready}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // SHA-256 "abc", no stalls
        expand(abc_blk);
        start_block(1'b1, 1'b0);
        feed(0, 1000);
        check_i("abc_latency", cycles, 67);
        check_i("abc_words", idx, 64);
        check("abc_digest", digest, DigAbc256);
        check("abc_dvalid", {255'd0, dvalid}, 256'd1);
        @(posedge clk);
        #1;
        check("abc_done_pulse", {255'd0, done}, 256'd0);
        check("abc_idle", {255'd0, busy}, 256'd0);

        // SHA-224 "abc"
        start_block(1'b1, 1'b1);
        feed(0, 1000);
        check_i("abc224_latency", cycles, 67);
        check("abc224_digest", digest, DigAbc224);

        // Two-block chain; mode_224 on the chained start must be ignored
        expand(two1_blk);
        start_block(1'b1, 1'b0);
        feed(0, 1000);
        expand(two2_blk);
        start_block(1'b0, 1'b1);
        check("two_dvalid_clr", {255'd0, dvalid}, 256'd0);
        feed(0, 1000);
        check("two_digest", digest, DigTwo);

        // "abc" with random W_t gaps
        expand(abc_blk);
        start_block(1'b1, 1'b0);
        feed(30, 1000);
        check_i("gap_latency", cycles, 67 + stalls);
        check_i("gap_words", idx, 64);
        check("gap_digest", digest, DigAbc256);

        // abort together with start in IDLE: nothing starts
        @(negedge clk);
        start = 1'b1;
        first_block = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first_block = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", {255'd0, busy}, 256'd0);

        // abort at t=30
        start_block(1'b1, 1'b0);
        feed(0, 30);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", {255'd0, busy}, 256'd0);
        check("abort_dvalid", {255'd0, dvalid}, 256'd0);
        pulses = 0;
        repeat (80) begin
            if (done) pulses++;
            @(posedge clk);
            #1;
        end
        check_i("abort_no_done", pulses, 0);
        start_block(1'b1, 1'b0);
        feed(0, 1000);
        check("abort_then_digest", digest, DigAbc256);

        // reset pulse during ROUND t=10
        start_block(1'b1, 1'b0);
        feed(0, 10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_ctrl", {252'd0, busy, done, dvalid, w_if.w_ready}, 256'd0);
        check("midrst_digest", digest, 256'd0);
        start_block(1'b1, 1'b0);
        feed(0, 1000);
        check("midrst_then_digest", digest, DigAbc256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
